hazard_tracker: RTL and testbench
=================================

// Module: hazard_tracker
// PURPOSE
//  Hazard/forwarding stage beside the ID-stage decoder of the 5-stage RV32I pipeline. Consumes decoder outputs
//  (rs1use, rs2use, hazard_optype, Branch) plus register addresses, tracks in-flight destinations of the EXE
//  and MEM stages in internal shadow registers, and drives ID-stage forward selects, load-use stall, IF/ID flush
//  and saturating stall/flush performance counters. Branches resolve in ID; regfile writes at negedge, so no WB forwarding.
// PARAMETERS
//  CNT_W     32  width of each performance counter
//  OPT_NONE  2'b00  hazard_optype: no rd write
//  OPT_ALU   2'b01  hazard_optype: rd valid at end of EXE (ALU, LUI, AUIPC, JAL/JALR)
//  OPT_LOAD  2'b10  hazard_optype: rd valid at end of MEM
//  OPT_STORE 2'b11  hazard_optype: store, no rd write
// PORTS
//  clk              in   1  clock, rising edge
//  rst_n            in   1  asynchronous reset, active-low
//  rs1use           in   1  ID inst reads rs1
//  rs2use           in   1  ID inst reads rs2
//  hazard_optype    in   2  ID inst class (OPT_*)
//  Branch           in   1  ID inst redirects PC (taken branch, JAL, JALR)
//  rs1_addr         in   5  ID rs1 index
//  rs2_addr         in   5  ID rs2 index
//  rd_addr          in   5  ID rd index
//  forward_ctrl_A   out  2  ID rs1 source: 00 regfile, 01 EXE ALU, 10 MEM ALU, 11 MEM load data
//  forward_ctrl_B   out  2  ID rs2 source, same encoding
//  forward_ctrl_ls  out  1  EXE store data taken from MEM load data
//  PC_EN_IF         out  1  PC write enable
//  reg_FD_EN        out  1  IF/ID register enable
//  reg_FD_flush     out  1  IF/ID register flush
//  reg_DE_flush     out  1  ID/EX register load bubble
//  stall_count      out  CNT_W  cycles with stall asserted
//  flush_count      out  CNT_W  cycles with reg_FD_flush asserted
// BEHAVIOUR
//  - Shadow state: {rd,optype} for EXE and MEM slots; rs2 and store flag for EXE slot. Reset: all 0 (NONE).
//  - Outputs at reset: forward selects 0, flush 0, counters 0; PC_EN_IF=reg_FD_EN=1 (combinational from empty state).
//  - Each rising edge: MEM slot <= EXE slot; EXE slot <= stall ? bubble(rd 0, NONE) : ID {rd,optype,rs2}.
//  - Match rule: a slot matches src iff optype in {ALU,LOAD}, rd!=0, rd==src, and corresponding rsXuse=1.
//  - stall = load in EXE matching rs1, or matching rs2 unless ID optype==STORE (store data deferred, see ls).
//  - stall=1 -> PC_EN_IF=0, reg_FD_EN=0, reg_DE_flush=1; else PC_EN_IF=reg_FD_EN=1, reg_DE_flush=0.
//  - reg_FD_flush = Branch & ~stall (Branch is computed on stale operands during a stall; suppressed).
//  - forward_ctrl_X: EXE ALU match -> 01; else MEM ALU match -> 10; else MEM load match -> 11; else 00.
//    EXE slot has priority over MEM. EXE load match gives 00 (stall covers it). rsXuse=0 -> 00.
//  - Store rs2 vs EXE load: forward_ctrl_B=00 in ID; next cycle forward_ctrl_ls=1 when EXE slot is store,
//    EXE rs2!=0, and MEM slot is LOAD with rd==EXE rs2.
//  - Counters increment by 1 on cycles with stall / reg_FD_flush; saturate at all-ones; no wrap.
//  - rst_n low mid-operation clears slots and counters immediately; no pending stall or forward survives.
// STRUCTURE
//  - Package rv32_hazard_pkg: OPT_* codes, FWD_* select codes (REG/EXE_ALU/MEM_ALU/MEM_LOAD).
//  - Sub-module sat_counter (CNT_W, inc, count) instantiated twice.
//  - Shadow slot registers and match/priority logic stay flat in this module.
// TESTING
//  - addi x5 then add x6,x5,x5 next -> forward_ctrl_A=B=01, no stall; one cycle later an independent
//    reader of x5 -> 10.
//  - lw x5 then add x6,x5,x0 -> one stall cycle (PC_EN_IF=0, reg_DE_flush=1), then forward_ctrl_A=11; stall_count=1.
//  - lw x5 then sw x5,0(x1) -> no stall, forward_ctrl_B=00, next cycle forward_ctrl_ls=1.
//  - addi x0,x0,1 then add x6,x0,x0 -> forward selects 00, no stall.
//  - lw x5 then beq x5,x1 (Branch=1) -> stall cycle with reg_FD_flush=0; next cycle reg_FD_flush=1, flush_count=1.
//  - Force counter to all-ones minus 1, two stall cycles -> stays all-ones; rst_n low mid-stall -> counters 0,
//    PC_EN_IF=1 asynchronously.

Source files
------------

// File: rtl/hazard_tracker_pkg.sv
// Shared encodings for the ID-stage hazard tracker: instruction classes and forward selects.
// Also holds the slot-match and forward-priority helpers used by the tracker.
// Pure declarations; no state.
package rv32_hazard_pkg;

  typedef enum logic [1:0] {
    OPT_NONE  = 2'b00,
    OPT_ALU   = 2'b01,
    OPT_LOAD  = 2'b10,
    OPT_STORE = 2'b11
  } optype_e;

  typedef enum logic [1:0] {
    FWD_REG      = 2'b00,
    FWD_EXE_ALU  = 2'b01,
    FWD_MEM_ALU  = 2'b10,
    FWD_MEM_LOAD = 2'b11
  } fwd_sel_e;

  // A pipeline slot feeds a source operand only if it writes a real register that the ID inst reads.
  function automatic logic slot_match(optype_e opt, logic [4:0] rd, logic [4:0] src, logic src_used);
    return src_used && (opt == OPT_ALU || opt == OPT_LOAD) && (rd != 5'd0) && (rd == src);
  endfunction

  // Youngest producer wins; a load still in EXE cannot forward (the stall covers it).
  function automatic fwd_sel_e pick_fwd(logic exe_hit, optype_e exe_opt, logic mem_hit, optype_e mem_opt);
    if (exe_hit) return (exe_opt == OPT_ALU) ? FWD_EXE_ALU : FWD_REG;
    if (mem_hit) return (mem_opt == OPT_ALU) ? FWD_MEM_ALU : FWD_MEM_LOAD;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_tracker_if.sv
// Decoder-side bundle into the hazard tracker and its control outputs back to the pipeline.
// master = decoder/pipeline side, slave = hazard tracker.
// No handshake: every field is valid every cycle.
interface hazard_tracker_if #(parameter int CNT_W = 32);
  import rv32_hazard_pkg::*;

  logic             rs1use;
  logic             rs2use;
  optype_e          hazard_optype;
  logic             Branch;
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic [4:0]       rd_addr;
  logic [1:0]       forward_ctrl_A;
  logic [1:0]       forward_ctrl_B;
  logic             forward_ctrl_ls;
  logic             PC_EN_IF;
  logic             reg_FD_EN;
  logic             reg_FD_flush;
  logic             reg_DE_flush;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output rs1use, rs2use, hazard_optype, Branch, rs1_addr, rs2_addr, rd_addr,
    input  forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls, PC_EN_IF, reg_FD_EN,
           reg_FD_flush, reg_DE_flush, stall_count, flush_count
  );

  modport slave (
    input  rs1use, rs2use, hazard_optype, Branch, rs1_addr, rs2_addr, rd_addr,
    output forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls, PC_EN_IF, reg_FD_EN,
           reg_FD_flush, reg_DE_flush, stall_count, flush_count
  );

endinterface

// File: rtl/hazard_tracker_sat_counter.sv
// Saturating event counter: counts cycles with inc high, holds at all-ones.
// Count visible one cycle after the counted event.
// No backpressure; inc is sampled every cycle.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: step by one unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) count_d = count_q + CNT_W'(1);
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_tracker.sv
// ID-stage hazard tracker: shadows EXE/MEM destinations, drives forward selects, load-use stall, IF/ID flush.
// Control outputs are combinational from ID inputs and shadow state; counters update one cycle later.
// Stall holds PC and IF/ID and injects a bubble into ID/EX; a flush is suppressed while stalling.
module hazard_tracker
  import rv32_hazard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  hazard_tracker_if.slave hz
);

  // Shadow slots mirroring what sits in EXE and MEM.
  logic [4:0] exe_rd_q, exe_rd_d;
  optype_e    exe_opt_q, exe_opt_d;
  logic [4:0] exe_rs2_q, exe_rs2_d;
  logic       exe_store_q, exe_store_d;
  logic [4:0] mem_rd_q, mem_rd_d;
  optype_e    mem_opt_q, mem_opt_d;

  logic exe_hit_a, exe_hit_b, mem_hit_a, mem_hit_b;
  logic stall;

  assign exe_hit_a = slot_match(exe_opt_q, exe_rd_q, hz.rs1_addr, hz.rs1use);
  assign exe_hit_b = slot_match(exe_opt_q, exe_rd_q, hz.rs2_addr, hz.rs2use);
  assign mem_hit_a = slot_match(mem_opt_q, mem_rd_q, hz.rs1_addr, hz.rs1use);
  assign mem_hit_b = slot_match(mem_opt_q, mem_rd_q, hz.rs2_addr, hz.rs2use);

  // Load-use stall; a store's data operand is fetched from MEM a cycle later instead of stalling.
  assign stall = (exe_opt_q == OPT_LOAD) &&
                 (exe_hit_a || (exe_hit_b && hz.hazard_optype != OPT_STORE));

  assign hz.forward_ctrl_A  = pick_fwd(exe_hit_a, exe_opt_q, mem_hit_a, mem_opt_q);
  assign hz.forward_ctrl_B  = pick_fwd(exe_hit_b, exe_opt_q, mem_hit_b, mem_opt_q);
  assign hz.forward_ctrl_ls = exe_store_q && (exe_rs2_q != 5'd0) &&
                              (mem_opt_q == OPT_LOAD) && (mem_rd_q == exe_rs2_q);
  assign hz.PC_EN_IF     = ~stall;
  assign hz.reg_FD_EN    = ~stall;
  assign hz.reg_DE_flush = stall;
  // Branch outcome is computed on stale operands during a stall, so it must not flush.
  assign hz.reg_FD_flush = hz.Branch && !stall;

  // Slot advance: MEM takes EXE; EXE takes ID or a bubble when stalling.
  always_comb begin
    mem_rd_d    = exe_rd_q;
    mem_opt_d   = exe_opt_q;
    exe_rd_d    = hz.rd_addr;
    exe_opt_d   = hz.hazard_optype;
    exe_rs2_d   = hz.rs2_addr;
    exe_store_d = (hz.hazard_optype == OPT_STORE);
    if (stall) begin
      exe_rd_d    = 5'd0;
      exe_opt_d   = OPT_NONE;
      exe_rs2_d   = 5'd0;
      exe_store_d = 1'b0;
    end
  end

  // Shadow slot registers, emptied asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exe_rd_q    <= 5'd0;
      exe_opt_q   <= OPT_NONE;
      exe_rs2_q   <= 5'd0;
      exe_store_q <= 1'b0;
      mem_rd_q    <= 5'd0;
      mem_opt_q   <= OPT_NONE;
    end else begin
      exe_rd_q    <= exe_rd_d;
      exe_opt_q   <= exe_opt_d;
      exe_rs2_q   <= exe_rs2_d;
      exe_store_q <= exe_store_d;
      mem_rd_q    <= mem_rd_d;
      mem_opt_q   <= mem_opt_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall),
    .count (hz.stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hz.reg_FD_flush),
    .count (hz.flush_count)
  );

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker with a narrow counter so saturation is reachable.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_hazard_tracker;
  import rv32_hazard_pkg::*;

  localparam int CW = 4;

  logic clk;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  hazard_tracker_if #(.CNT_W(CW)) hz ();

  hazard_tracker #(.CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic r1u, input logic r2u, input optype_e opt, input logic br,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    hz.rs1use        = r1u;
    hz.rs2use        = r2u;
    hz.hazard_optype = opt;
    hz.Branch        = br;
    hz.rs1_addr      = rs1;
    hz.rs2_addr      = rs2;
    hz.rd_addr       = rd;
  endtask

  task automatic idle();
    set_id(1'b0, 1'b0, OPT_NONE, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    sample();
    // Reset state
    chk("rst_fwdA",   hz.forward_ctrl_A, FWD_REG);
    chk("rst_fwdB",   hz.forward_ctrl_B, FWD_REG);
    chk("rst_ls",     hz.forward_ctrl_ls, 1'b0);
    chk("rst_pcen",   hz.PC_EN_IF, 1'b1);
    chk("rst_fden",   hz.reg_FD_EN, 1'b1);
    chk("rst_fdfl",   hz.reg_FD_flush, 1'b0);
    chk("rst_defl",   hz.reg_DE_flush, 1'b0);
    chk("rst_scnt",   hz.stall_count, 0);
    chk("rst_fcnt",   hz.flush_count, 0);
    #2 rst_n = 1'b1;
    tick();

    // addi x5,x1,imm ; add x6,x5,x5 ; add x7,x5,x0
    set_id(1'b1, 1'b0, OPT_ALU, 1'b0, 5'd1, 5'd0, 5'd5);
    sample();
    chk("addi_fwdA", hz.forward_ctrl_A, FWD_REG);
    tick();
    set_id(1'b1, 1'b1, OPT_ALU, 1'b0, 5'd5, 5'd5, 5'd6);
    sample();
    chk("alu_fwdA",  hz.forward_ctrl_A, FWD_EXE_ALU);
    chk("alu_fwdB",  hz.forward_ctrl_B, FWD_EXE_ALU);
    chk("alu_pcen",  hz.PC_EN_IF, 1'b1);
    tick();
    set_id(1'b1, 1'b1, OPT_ALU, 1'b0, 5'd5, 5'd0, 5'd7);
    sample();
    chk("mem_fwdA",  hz.forward_ctrl_A, FWD_MEM_ALU);
    chk("mem_fwdB",  hz.forward_ctrl_B, FWD_REG);
    tick();
    idle(); tick(); tick();

    // lw x5,0(x1) ; add x6,x5,x0 -> one stall then load forward
    set_id(1'b1, 1'b0, OPT_LOAD, 1'b0, 5'd1, 5'd0, 5'd5);
    sample();
    chk("lw_nostall", hz.PC_EN_IF, 1'b1);
    tick();
    set_id(1'b1, 1'b1, OPT_ALU, 1'b0, 5'd5, 5'd0, 5'd6);
    sample();
    chk("lu_pcen",   hz.PC_EN_IF, 1'b0);
    chk("lu_fden",   hz.reg_FD_EN, 1'b0);
    chk("lu_defl",   hz.reg_DE_flush, 1'b1);
    chk("lu_fwdA0",  hz.forward_ctrl_A, FWD_REG);
    tick();
    sample();
    chk("lu2_pcen",  hz.PC_EN_IF, 1'b1);
    chk("lu2_defl",  hz.reg_DE_flush, 1'b0);
    chk("lu2_fwdA",  hz.forward_ctrl_A, FWD_MEM_LOAD);
    chk("lu2_scnt",  hz.stall_count, 1);
    tick();
    idle(); tick(); tick();

    // lw x5,0(x1) ; sw x5,0(x1) -> no stall, store data from MEM load next cycle
    set_id(1'b1, 1'b0, OPT_LOAD, 1'b0, 5'd1, 5'd0, 5'd5);
    tick();
    set_id(1'b1, 1'b1, OPT_STORE, 1'b0, 5'd1, 5'd5, 5'd3);
    sample();
    chk("st_pcen",   hz.PC_EN_IF, 1'b1);
    chk("st_fwdB",   hz.forward_ctrl_B, FWD_REG);
    chk("st_ls0",    hz.forward_ctrl_ls, 1'b0);
    tick();
    idle();
    sample();
    chk("st_ls1",    hz.forward_ctrl_ls, 1'b1);
    chk("st_scnt",   hz.stall_count, 1);
    tick();
    sample();
    chk("st_ls_off", hz.forward_ctrl_ls, 1'b0);
    tick();

    // addi x0,x0,1 ; add x6,x0,x0 -> x0 never forwards
    set_id(1'b1, 1'b0, OPT_ALU, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    set_id(1'b1, 1'b1, OPT_ALU, 1'b0, 5'd0, 5'd0, 5'd6);
    sample();
    chk("x0_fwdA",   hz.forward_ctrl_A, FWD_REG);
    chk("x0_fwdB",   hz.forward_ctrl_B, FWD_REG);
    chk("x0_pcen",   hz.PC_EN_IF, 1'b1);
    tick();
    idle(); tick(); tick();

    // lw x5 ; beq x5,x1 taken -> flush suppressed during stall, then flush
    set_id(1'b1, 1'b0, OPT_LOAD, 1'b0, 5'd1, 5'd0, 5'd5);
    tick();
    set_id(1'b1, 1'b1, OPT_NONE, 1'b1, 5'd5, 5'd1, 5'd0);
    sample();
    chk("br_pcen",   hz.PC_EN_IF, 1'b0);
    chk("br_fdfl0",  hz.reg_FD_flush, 1'b0);
    tick();
    sample();
    chk("br_fdfl1",  hz.reg_FD_flush, 1'b1);
    chk("br_fwdA",   hz.forward_ctrl_A, FWD_MEM_LOAD);
    chk("br_fcnt0",  hz.flush_count, 0);
    chk("br_scnt",   hz.stall_count, 2);
    tick();
    idle();
    sample();
    chk("br_fcnt1",  hz.flush_count, 1);
    tick(); tick();

    // lw x5,0(x5) held in ID stalls every other cycle; drive the stall counter up to 14
    set_id(1'b1, 1'b0, OPT_LOAD, 1'b0, 5'd5, 5'd0, 5'd5);
    for (int i = 0; i < 24; i++) tick();
    sample();
    chk("sat_14",    hz.stall_count, 14);
    chk("sat_nost",  hz.PC_EN_IF, 1'b1);
    tick();
    sample();
    chk("sat_st1",   hz.PC_EN_IF, 1'b0);
    tick();
    sample();
    chk("sat_15",    hz.stall_count, 15);
    tick();
    sample();
    chk("sat_st2",   hz.PC_EN_IF, 1'b0);
    tick();
    sample();
    chk("sat_hold",  hz.stall_count, 15);
    tick();
    sample();
    chk("pre_rst_st", hz.PC_EN_IF, 1'b0);

    // Asynchronous reset in the middle of a stall
    #1 rst_n = 1'b0;
    #1;
    chk("arst_pcen", hz.PC_EN_IF, 1'b1);
    chk("arst_defl", hz.reg_DE_flush, 1'b0);
    chk("arst_scnt", hz.stall_count, 0);
    chk("arst_fcnt", hz.flush_count, 0);
    idle();
    #1 rst_n = 1'b1;
    tick();
    sample();
    chk("post_scnt", hz.stall_count, 0);
    chk("post_fwdA", hz.forward_ctrl_A, FWD_REG);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
